morse_digit_decoder: RTL and testbench

//   Receives the single-line Morse waveform produced by the digit encoder (LED drive) and recovers the digit 0-9.

---
 rtl/morse_digit_decoder_if.sv | 28 ++
 rtl/morse_digit_decoder.sv | 207 ++++++++++++++++++++
 tb/tb_morse_digit_decoder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/morse_digit_decoder_if.sv
// Signal bundle between the Morse line source and the digit decoder.
// Defining MORSE_DEC_ERR_COUNT_EN adds the err_count output.
interface morse_digit_decoder_if;
  logic       morse_in;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       code_err;
  logic       busy;
`ifdef MORSE_DEC_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  modport master (
    output morse_in,
    input  digit_out, digit_valid, code_err, busy
`ifdef MORSE_DEC_ERR_COUNT_EN
    , input err_count
`endif
  );

  modport slave (
    input  morse_in,
    output digit_out, digit_valid, code_err, busy
`ifdef MORSE_DEC_ERR_COUNT_EN
    , output err_count
`endif
  );
endinterface

// File: rtl/morse_digit_decoder.sv
// Recovers a 0-9 digit from a 5-symbol Morse mark/space waveform.
// Defining MORSE_DEC_ERR_COUNT_EN adds a saturating 8-bit error counter output.
module morse_digit_decoder #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned DOT_LEN     = CLK_HZ,
  parameter int unsigned SYMBOL_GAP  = CLK_HZ / 2,
  parameter int unsigned DOT_MIN     = DOT_LEN / 2,
  parameter int unsigned DASH_THRESH = 2 * DOT_LEN,
  parameter int unsigned DASH_MAX    = 4 * DOT_LEN,
  parameter int unsigned GAP_TIMEOUT = 4 * SYMBOL_GAP
) (
  input logic                  clk,
  input logic                  rst_n,
  morse_digit_decoder_if.slave bus
);

  localparam logic [31:0] DOT_MIN_C  = 32'(DOT_MIN);
  localparam logic [31:0] DASH_THR_C = 32'(DASH_THRESH);
  localparam logic [31:0] DASH_MAX_C = 32'(DASH_MAX);
  localparam logic [31:0] MARK_SAT_C = 32'(DASH_MAX) + 32'd1;
  localparam logic [31:0] GAP_TO_C   = 32'(GAP_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SPACE,
    EMIT,
    ERR,
    DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sync_q, sync_d;
  logic [1:0]  settle_q, settle_d;
  logic        armed_q, armed_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  shreg_q, shreg_d;
  logic [2:0]  sym_cnt_q, sym_cnt_d;
  logic [3:0]  digit_q, digit_d;
  logic        digit_valid_q, digit_valid_d;
  logic        code_err_q, code_err_d;

  logic        line;
  logic        rise;
  logic        fall;
  logic        mark_ok;
  logic        dec_hit;
  logic [3:0]  dec_digit;

  assign line    = sync_q[1];
  assign rise    = sync_q[1] & ~sync_q[2];
  assign fall    = ~sync_q[1] & sync_q[2];
  assign mark_ok = (cnt_q >= DOT_MIN_C) && (cnt_q <= DASH_MAX_C);

  // A line already high at reset release must not count as a rise, so rises
  // are only honoured once the settled synchronizer has seen the line low.
  always_comb begin
    sync_d   = {sync_q[1:0], bus.morse_in};
    settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == 2'd3) && !line);
  end

  always_comb begin
    dec_hit   = 1'b1;
    dec_digit = 4'd0;
    case (shreg_q)
      5'b11111: dec_digit = 4'd0;
      5'b01111: dec_digit = 4'd1;
      5'b00111: dec_digit = 4'd2;
      5'b00011: dec_digit = 4'd3;
      5'b00001: dec_digit = 4'd4;
      5'b00000: dec_digit = 4'd5;
      5'b10000: dec_digit = 4'd6;
      5'b11000: dec_digit = 4'd7;
      5'b11100: dec_digit = 4'd8;
      5'b11110: dec_digit = 4'd9;
      default:  dec_hit   = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    sym_cnt_d     = sym_cnt_q;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    code_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise && armed_q) begin
          state_d   = MARK;
          cnt_d     = 32'd1;
          shreg_d   = 5'd0;
          sym_cnt_d = 3'd0;
        end
      end
      MARK: begin
        if (fall) begin
          if (!mark_ok) begin
            state_d = ERR;
          end else begin
            shreg_d   = {shreg_q[3:0], (cnt_q >= DASH_THR_C)};
            sym_cnt_d = sym_cnt_q + 3'd1;
            if (sym_cnt_q == 3'd4) begin
              state_d = EMIT;
            end else begin
              state_d = SPACE;
              cnt_d   = 32'd1;
            end
          end
        end else if (cnt_q < MARK_SAT_C) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      SPACE: begin
        if (rise) begin
          state_d = MARK;
          cnt_d   = 32'd1;
        end else if (cnt_q == GAP_TO_C) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      EMIT: begin
        if (dec_hit) begin
          digit_d       = dec_digit;
          digit_valid_d = 1'b1;
        end else begin
          code_err_d = 1'b1;
        end
        state_d = IDLE;
      end
      ERR: begin
        code_err_d = 1'b1;
        state_d    = DRAIN;
        cnt_d      = 32'd0;
      end
      DRAIN: begin
        // Any mark restarts the quiet period so we only rejoin between digits.
        if (line) begin
          cnt_d = 32'd0;
        end else if (cnt_q == GAP_TO_C) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sync_q        <= 3'd0;
      settle_q      <= 2'd0;
      armed_q       <= 1'b0;
      cnt_q         <= 32'd0;
      shreg_q       <= 5'd0;
      sym_cnt_q     <= 3'd0;
      digit_q       <= 4'd0;
      digit_valid_q <= 1'b0;
      code_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      settle_q      <= settle_d;
      armed_q       <= armed_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      sym_cnt_q     <= sym_cnt_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      code_err_q    <= code_err_d;
    end
  end

  assign bus.digit_out   = digit_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.code_err    = code_err_q;
  assign bus.busy        = (state_q != IDLE);

`ifdef MORSE_DEC_ERR_COUNT_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (code_err_d && (err_count_q != 8'd255)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign bus.err_count = err_count_q;
`endif

endmodule

// File: tb/tb_morse_digit_decoder.sv
// Scoreboard bench for morse_digit_decoder at CLK_HZ=100 (dot 100, dash 300, gap 50 cycles).
// Optional MORSE_DEC_ERR_COUNT_EN section drives 300 forced errors.
`timescale 1ns/1ps
module tb_morse_digit_decoder;

  typedef struct {
    bit         is_err;
    logic [3:0] digit;
    bit         chk_lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   fall_cyc;
  exp_t sb[$];
  exp_t got;

  logic [4:0] pat_tbl [10] = '{5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001,
                               5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110};

  morse_digit_decoder_if bus_if ();

  morse_digit_decoder #(.CLK_HZ(100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives the line for n sampling edges; assumes the caller sits on a negedge.
  task automatic applyStimulus(input logic lvl, input int n);
    if (!lvl && bus_if.morse_in) fall_cyc = cyc;
    bus_if.morse_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic sendPattern(input logic [4:0] pat);
    for (int i = 4; i >= 0; i--) begin
      applyStimulus(1'b1, pat[i] ? 300 : 100);
      if (i > 0) applyStimulus(1'b0, 50);
    end
  endtask

  task automatic pushExp(input bit is_err, input logic [3:0] d, input bit lat);
    exp_t e;
    e.is_err  = is_err;
    e.digit   = d;
    e.chk_lat = lat;
    sb.push_back(e);
  endtask

  // Monitor: every output pulse pops one expected response from the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (bus_if.digit_valid || bus_if.code_err)) begin
      checkOutput("valid_err_exclusive", 32'(bus_if.digit_valid & bus_if.code_err), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got valid=%0b err=%0b expected none",
                 bus_if.digit_valid, bus_if.code_err);
      end else begin
        got = sb.pop_front();
        checkOutput("pulse_is_err", 32'(bus_if.code_err), 32'(got.is_err));
        if (!got.is_err) checkOutput("digit_out", 32'(bus_if.digit_out), 32'(got.digit));
        if (got.chk_lat) checkOutput("valid_latency", 32'(cyc - fall_cyc), 32'd4);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks          = 0;
    errors          = 0;
    cyc             = 0;
    fall_cyc        = 0;
    bus_if.morse_in = 1'b0;
    rst_n           = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_digit_out", 32'(bus_if.digit_out), 32'd0);
    checkOutput("reset_valid", 32'(bus_if.digit_valid), 32'd0);
    checkOutput("reset_err", 32'(bus_if.code_err), 32'd0);
    checkOutput("reset_busy", 32'(bus_if.busy), 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 10);

    $display("[TB] digit 7 with latency check");
    pushExp(1'b0, 4'd7, 1'b1);
    sendPattern(pat_tbl[7]);
    applyStimulus(1'b0, 20);
    checkOutput("busy_after_7", 32'(bus_if.busy), 32'd0);
    applyStimulus(1'b0, 280);

    $display("[TB] all ten digits");
    for (int d = 0; d < 10; d++) begin
      pushExp(1'b0, 4'(d), 1'b0);
      sendPattern(pat_tbl[d]);
      applyStimulus(1'b0, 20);
      checkOutput("busy_between_digits", 32'(bus_if.busy), 32'd0);
      applyStimulus(1'b0, 280);
    end

    $display("[TB] boundary marks 50/199/200/400/200 -> 2");
    pushExp(1'b0, 4'd2, 1'b1);
    applyStimulus(1'b1, 50);  applyStimulus(1'b0, 50);
    applyStimulus(1'b1, 199); applyStimulus(1'b0, 50);
    applyStimulus(1'b1, 200); applyStimulus(1'b0, 50);
    applyStimulus(1'b1, 400); applyStimulus(1'b0, 50);
    applyStimulus(1'b1, 200); applyStimulus(1'b0, 300);

    $display("[TB] reset during third symbol");
    applyStimulus(1'b1, 100); applyStimulus(1'b0, 50);
    applyStimulus(1'b1, 100); applyStimulus(1'b0, 50);
    applyStimulus(1'b1, 50);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_digit_out", 32'(bus_if.digit_out), 32'd0);
    checkOutput("midreset_busy", 32'(bus_if.busy), 32'd0);
    checkOutput("midreset_valid", 32'(bus_if.digit_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 50);
    applyStimulus(1'b0, 300);
    pushExp(1'b0, 4'd4, 1'b1);
    sendPattern(pat_tbl[4]);
    applyStimulus(1'b0, 300);

    $display("[TB] short mark 49");
    pushExp(1'b1, 4'd0, 1'b0);
    applyStimulus(1'b1, 49);
    applyStimulus(1'b0, 300);
    checkOutput("busy_after_short", 32'(bus_if.busy), 32'd0);
    pushExp(1'b0, 4'd3, 1'b0);
    sendPattern(pat_tbl[3]);
    applyStimulus(1'b0, 300);

    $display("[TB] long mark 401");
    pushExp(1'b1, 4'd0, 1'b0);
    applyStimulus(1'b1, 401);
    applyStimulus(1'b0, 300);
    pushExp(1'b0, 4'd8, 1'b0);
    sendPattern(pat_tbl[8]);
    applyStimulus(1'b0, 300);

    $display("[TB] illegal pattern 01010");
    pushExp(1'b1, 4'd0, 1'b0);
    sendPattern(5'b01010);
    applyStimulus(1'b0, 20);
    checkOutput("digit_held_on_bad_pattern", 32'(bus_if.digit_out), 32'd8);
    applyStimulus(1'b0, 280);

    $display("[TB] gap timeout after three marks");
    pushExp(1'b1, 4'd0, 1'b0);
    applyStimulus(1'b1, 100); applyStimulus(1'b0, 50);
    applyStimulus(1'b1, 300); applyStimulus(1'b0, 50);
    applyStimulus(1'b1, 100); applyStimulus(1'b0, 500);
    checkOutput("busy_after_drain", 32'(bus_if.busy), 32'd0);
    pushExp(1'b0, 4'd1, 1'b0);
    sendPattern(pat_tbl[1]);
    applyStimulus(1'b0, 300);

`ifdef MORSE_DEC_ERR_COUNT_EN
    $display("[TB] 300 forced errors");
    for (int i = 0; i < 300; i++) begin
      pushExp(1'b1, 4'd0, 1'b0);
      applyStimulus(1'b1, 10);
      applyStimulus(1'b0, 215);
    end
    checkOutput("err_count_saturated", 32'(bus_if.err_count), 32'd255);
`endif

    applyStimulus(1'b0, 20);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
